// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a multi-cycle,
// word-addressed data SRAM and freezes the pipeline (ready = 0) while the
// access is in flight. Out-of-range accesses are flagged without touching
// the SRAM.
module dmem_access_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       alu_res,
    input  logic [31:0]       rm_val,
    input  logic [31:0]       sram_rdata,
    output logic              ready,
    output logic [31:0]       data_mem,
    output logic              addr_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata
);

    // Counter is wide enough to hold WAIT_CYCLES so the final increment
    // out of the last ACCESS cycle never wraps.
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

    localparam logic [31:0]      BASE     = 32'(BASE_ADDR);
    localparam logic [31:0]      SPAN     = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               is_write_q, is_write_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [31:0]        wdata_q,    wdata_d;
    logic [31:0]        data_mem_q, data_mem_d;
    logic               addr_err_q, addr_err_d;

    logic               req;
    logic               in_range;
    logic               cnt_last;
    logic [31:0]        off;
    logic [ADDR_W-1:0]  word_idx;

    // Request decode and byte-to-word address translation. A store wins
    // when both enables are set; the low two offset bits are simply dropped.
    always_comb begin
        req      = MEM_R_EN | MEM_W_EN;
        off      = alu_res - BASE;
        in_range = (alu_res >= BASE) && (off < SPAN);
        word_idx = off[ADDR_W+1:2];
        cnt_last = (cnt_q == CNT_LAST);
    end

    // State and datapath registers, cleared synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_mem_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_mem_q <= data_mem_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next-state logic: IDLE dispatches, ACCESS counts out the SRAM
    // latency, DONE always hands back to IDLE after one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = in_range ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath updates: latch the request on dispatch, capture the load
    // result (or zero for a store) on the final ACCESS edge.
    always_comb begin
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_mem_d = data_mem_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (in_range) begin
                        cnt_d      = '0;
                        is_write_d = MEM_W_EN;
                        addr_d     = word_idx;
                        wdata_d    = rm_val;
                    end else begin
                        data_mem_d = '0;
                        addr_err_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    data_mem_d = is_write_q ? 32'h0 : sram_rdata;
                    addr_err_d = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Output decode: freeze the pipeline whenever a request is pending or
    // being serviced; strobe the SRAM only while in ACCESS.
    always_comb begin
        ready   = 1'b1;
        sram_en = 1'b0;
        sram_we = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready = ~req;
            end
            ST_ACCESS: begin
                ready   = 1'b0;
                sram_en = 1'b1;
                sram_we = is_write_q;
            end
            ST_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    assign data_mem   = data_mem_q;
    assign addr_err   = addr_err_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: a driver issues requests like the
// MEM stage would, a reference model predicts each transaction's outcome,
// and a negedge monitor measures what the DUT did and compares.
module tb_dmem_access_ctrl;

    localparam int BASE  = 1024;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int WAITC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   alu_res;
    logic [31:0]   rm_val;
    logic [31:0]   sram_rdata;
    logic          ready;
    logic [31:0]   data_mem;
    logic          addr_err;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;

    dmem_access_ctrl #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(WAITC)
    ) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .alu_res(alu_res), .rm_val(rm_val), .sram_rdata(sram_rdata),
        .ready(ready), .data_mem(data_mem), .addr_err(addr_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write on enabled clock edges.
    logic [31:0] sram_mem [DEPTH];
    assign sram_rdata = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (sram_en === 1'b1 && sram_we === 1'b1) sram_mem[sram_addr] <= sram_wdata;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          low;
        int          en_cyc;
        int          we_cyc;
        logic [5:0]  idx;
        logic [31:0] wdata;
        logic        wr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: measure each transaction (ready-low run, SRAM strobes,
    // address/data on the strobe) and compare at the DONE cycle.
    int low_n = 0, en_n = 0, we_n = 0;
    bit addr_bad = 1'b0;
    always @(negedge clk) begin
        if (mon_en && rst === 1'b0) begin
            if (ready === 1'b0) begin
                low_n++;
                if (sram_en === 1'b1) begin
                    en_n++;
                    if (sram_we === 1'b1) we_n++;
                    if (sb.size() > 0) begin
                        if (sram_addr !== sb[0].idx) addr_bad = 1'b1;
                        if (sb[0].wr && sram_wdata !== sb[0].wdata) addr_bad = 1'b1;
                    end
                end
            end else if (low_n > 0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done with no pending txn, required none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ready_low_cycles", 32'(low_n), 32'(e.low));
                    check("sram_en_cycles", 32'(en_n), 32'(e.en_cyc));
                    check("sram_we_cycles", 32'(we_n), 32'(e.we_cyc));
                    check("sram_addr_wdata", {31'd0, addr_bad}, 32'd0);
                    check("data_mem", data_mem, e.data);
                    check("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                    check("done_sram_en", {31'd0, sram_en}, 32'd0);
                end
                low_n = 0; en_n = 0; we_n = 0; addr_bad = 1'b0;
            end else begin
                check("idle_sram_en", {31'd0, sram_en}, 32'd0);
            end
        end
    end

    // Drive one request (called at posedge+1), predict it, and hold it
    // until DONE has been seen; optionally scramble inputs while frozen.
    task automatic issue(bit r, bit w, logic [31:0] a, logic [31:0] d, bit scramble);
        exp_t   e;
        longint off;
        bit     inr;
        int     n;
        off = longint'(a) - longint'(BASE);
        inr = (off >= 0) && (off < 4 * DEPTH);
        e.wr    = w;
        e.wdata = d;
        e.idx   = inr ? 6'(off / 4) : 6'd0;
        if (!inr) begin
            e.data = 32'h0; e.err = 1'b1; e.low = 1; e.en_cyc = 0; e.we_cyc = 0;
        end else begin
            e.err    = 1'b0;
            e.low    = 1 + WAITC;
            e.en_cyc = WAITC;
            e.we_cyc = w ? WAITC : 0;
            e.data   = w ? 32'h0 : ref_mem[e.idx];
            if (w) ref_mem[e.idx] = d;
        end
        sb.push_back(e);
        $display("[TB] txn r=%0b w=%0b addr=%h wdata=%h -> in_range=%0b idx=%0d exp_data=%h exp_err=%0b",
                 r, w, a, d, inr, e.idx, e.data, e.err);
        MEM_R_EN = r; MEM_W_EN = w; alu_res = a; rm_val = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL ready_timeout: got ready low %0d cycles, required <= %0d", n, 1 + WAITC);
                break;
            end
            @(posedge clk); #1;
            if (scramble) begin
                MEM_R_EN = 1'($urandom_range(0, 1));
                MEM_W_EN = 1'($urandom_range(0, 1));
                alu_res  = $urandom;
                rm_val   = $urandom;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        alu_res = $urandom; rm_val = $urandom;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          k, sel;
        logic [31:0] a;
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; alu_res = '0; rm_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = $urandom;
            sram_mem[i] = ref_mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_data_mem", data_mem, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_sram_en", {31'd0, sram_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Directed cases
        issue(0, 1, 32'd1032, 32'hDEADBEEF, 0); idle(1);
        issue(1, 0, 32'd1024, 32'h0, 0);        idle(1);
        issue(1, 0, 32'd1032, 32'h0, 0);        idle(1);
        issue(1, 0, 32'd1020, 32'h0, 0);        idle(1);
        issue(1, 0, 32'd1280, 32'h0, 0);        idle(1);
        issue(1, 1, 32'd1028, 32'd7, 0);        idle(1);
        issue(1, 0, 32'd1028, 32'h0, 0);        idle(1);
        issue(0, 1, 32'd1027, 32'h0BADF00D, 0);
        issue(1, 0, 32'd1024, 32'h0, 0);
        issue(1, 0, 32'd1279, 32'h0, 1);
        issue(0, 1, 32'hFFFFFFFF, 32'h1, 1);    idle(2);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            k   = $urandom_range(1, 3);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: a = 32'(BASE + $urandom_range(0, 255));
                3:       a = 32'(BASE - 4 + $urandom_range(0, 3));
                4:       a = 32'(BASE + 256 + $urandom_range(0, 3));
                default: a = $urandom;
            endcase
            issue(k[0], k[1], a, $urandom, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        idle(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        // Reset in the second ACCESS cycle of a load
        issue(0, 1, 32'd1036, 32'hA5A50001, 0);
        issue(1, 0, 32'd1036, 32'h0, 0);
        idle(2);
        check("pre_rst_data_mem", data_mem, 32'hA5A50001);
        mon_en = 1'b0;
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; alu_res = 32'd1040; rm_val = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_access_sram_en", {31'd0, sram_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_sram_en", {31'd0, sram_en}, 32'd0);
        check("post_rst_sram_we", {31'd0, sram_we}, 32'd0);
        check("post_rst_data_mem", data_mem, 32'd0);
        check("post_rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("post_rst_ready_req", {31'd0, ready}, 32'd0);
        MEM_R_EN = 1'b0;
        #1;
        check("post_rst_ready_noreq", {31'd0, ready}, 32'd1);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
